// File: rtl/mem_io_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_io_responder_pkg
// Shared constants and types for the CPU-side memory/IO responder:
//   - bus widths (byte data, 32-bit byte address)
//   - IO window select (mem_a[17:16] == IO_BASE_HI)
//   - IO register offsets (UART data, counter bytes)
//   - read-source select type and a byte-extract helper
// -----------------------------------------------------------------------------
package mem_io_responder_pkg;

    localparam int BYTE_W    = 8;
    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 32;

    // IO window occupies the top quarter of the 18-bit decoded space
    localparam int IO_SEL_HI = 17;
    localparam int IO_SEL_LO = 16;
    localparam int DEC_W     = IO_SEL_HI + 1;

    localparam logic [1:0] IO_BASE_HI = 2'b11;

    localparam logic [2:0] OFF_UART = 3'd0;
    localparam logic [2:0] OFF_CNT0 = 3'd4;
    localparam logic [2:0] OFF_CNT1 = 3'd5;
    localparam logic [2:0] OFF_CNT2 = 3'd6;
    localparam logic [2:0] OFF_CNT3 = 3'd7;

    // Which registered source drives mem_din
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_IO   = 2'd2
    } rd_sel_e;

    // Extract byte 'idx' (0 = LSB) of a 32-bit word
    function automatic logic [BYTE_W-1:0] byte_of(input logic [CNT_W-1:0] word,
                                                  input logic [1:0]       idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// -----------------------------------------------------------------------------
// mem_io_responder_if
// CPU memory bus between the core (master) and the responder (slave).
//   rdy_in         core ready; low = bus ignored
//   mem_a          byte address
//   mem_dout       write data from core
//   mem_wr         1 = write, 0 = read
//   mem_din        read data to core (one-cycle latency)
//   io_buffer_full TX FIFO near-full back-pressure to core
// -----------------------------------------------------------------------------
interface mem_io_responder_if;
    import mem_io_responder_pkg::*;

    logic                rdy_in;
    logic [ADDR_W-1:0]   mem_a;
    logic [BYTE_W-1:0]   mem_dout;
    logic                mem_wr;
    logic [BYTE_W-1:0]   mem_din;
    logic                io_buffer_full;

    modport master (
        output rdy_in, mem_a, mem_dout, mem_wr,
        input  mem_din, io_buffer_full
    );

    modport slave (
        input  rdy_in, mem_a, mem_dout, mem_wr,
        output mem_din, io_buffer_full
    );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO, 2**AW entries, pointers AW+1 bits wide so that
// full/empty fall out of the MSB compare and wrap naturally.
//   clk_in, rst_in  clock, synchronous active-low reset (pointers only)
//   push, din       write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop, dout       read request; dout is the current head (show-ahead)
//   empty, full     status
//   free_cnt        number of free entries (0 .. 2**AW)
// -----------------------------------------------------------------------------
module byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       free_cnt
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [BYTE_W-1:0] mem_r [2**AW];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];
    assign free_cnt  = DEPTH - (wr_ptr_r - rd_ptr_r);

    // Pointer update; reset discards all contents
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        end
    end

    // Entry storage; contents need no reset since pointers define validity
    always_ff @(posedge clk_in) begin
        if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
// Far-end responder of the CPU memory bus: 2**RAM_AW bytes of RAM plus an
// IO window at mem_a[17:16]==2'b11 holding a UART data port (RX/TX FIFOs),
// a free-running 32-bit cycle counter with snapshot, and a stop register.
//   clk_in, rst_in    clock, synchronous active-low reset
//   bus (slave)       rdy_in, mem_a, mem_dout, mem_wr, mem_din, io_buffer_full
//   tx_data/valid     TX FIFO head toward the UART transmitter
//   tx_ready          transmitter accepts the head byte
//   rx_data/valid     byte from the UART receiver
//   rx_ready          RX FIFO not full
//   program_done      sticky, set by a write to the stop register (offset 4)
//   tx_overflow       sticky, set when a TX push is dropped
// -----------------------------------------------------------------------------
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_AW      = 17,
    parameter int FIFO_AW     = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    mem_io_responder_if.slave  bus,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               program_done,
    output logic               tx_overflow
);

    // ---------------- address decode ----------------
    logic [DEC_W-1:0]   dec_addr_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic [2:0]         off_s;
    logic               io_s;
    logic               ram_hit_s;
    logic               cpu_rd_s;
    logic               cpu_wr_s;
    logic               unused_s;

    assign dec_addr_s = bus.mem_a[DEC_W-1:0];
    assign ram_idx_s  = bus.mem_a[RAM_AW-1:0];
    assign off_s      = bus.mem_a[2:0];
    assign io_s       = (dec_addr_s[IO_SEL_HI:IO_SEL_LO] == IO_BASE_HI);
    // Bits between RAM_AW and the IO select must be zero for a RAM hit
    assign ram_hit_s  = !io_s && ((dec_addr_s >> RAM_AW) == {DEC_W{1'b0}});
    assign cpu_rd_s   = bus.rdy_in && !bus.mem_wr;
    assign cpu_wr_s   = bus.rdy_in &&  bus.mem_wr;

    // ---------------- state ----------------
    logic [BYTE_W-1:0]  ram_r [2**RAM_AW];
    logic [BYTE_W-1:0]  ram_q_r;
    logic [BYTE_W-1:0]  io_q_r;
    rd_sel_e            rd_sel_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   snap_r;
    logic               program_done_r;
    logic               tx_overflow_r;
    logic               io_full_r;

    // ---------------- FIFO handshake ----------------
    logic [BYTE_W-1:0]  tx_dout_s;
    logic               tx_empty_s;
    logic               tx_full_s;
    logic [FIFO_AW:0]   tx_free_s;
    logic [BYTE_W-1:0]  rx_dout_s;
    logic               rx_empty_s;
    logic               rx_full_s;
    logic [FIFO_AW:0]   rx_free_s;

    logic               io_wr_ok_s;
    logic               uart_wr_s;
    logic               stop_wr_s;
    logic               tx_push_req_s;
    logic               tx_push_ok_s;
    logic [BYTE_W-1:0]  tx_push_data_s;
    logic               tx_pop_s;
    logic               rx_push_s;
    logic               rx_pop_s;
    logic               cnt_rd_s;
    logic               ram_we_s;
    logic [FIFO_AW+1:0] tx_free_next_s;

    // Once the program has stopped, the IO window no longer accepts writes
    assign io_wr_ok_s     = cpu_wr_s && io_s && !program_done_r;
    assign uart_wr_s      = io_wr_ok_s && (off_s == OFF_UART) && (bus.mem_dout != 8'h00);
    assign stop_wr_s      = io_wr_ok_s && (off_s == OFF_CNT0);
    assign tx_push_req_s  = uart_wr_s || stop_wr_s;
    // Stop marker is a literal 0x00 that bypasses the zero filter
    assign tx_push_data_s = stop_wr_s ? 8'h00 : bus.mem_dout;
    assign tx_pop_s       = !tx_empty_s && tx_ready;
    assign tx_push_ok_s   = tx_push_req_s && (!tx_full_s || tx_pop_s);
    assign rx_push_s      = rx_valid && !rx_full_s;
    assign rx_pop_s       = cpu_rd_s && io_s && (off_s == OFF_UART) && !rx_empty_s;
    assign cnt_rd_s       = cpu_rd_s && io_s && (off_s == OFF_CNT0);
    assign ram_we_s       = cpu_wr_s && ram_hit_s;

    assign tx_free_next_s = {1'b0, tx_free_s}
                          + {{(FIFO_AW+1){1'b0}}, tx_pop_s}
                          - {{(FIFO_AW+1){1'b0}}, tx_push_ok_s};

    byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (tx_push_ok_s),
        .pop      (tx_pop_s),
        .din      (tx_push_data_s),
        .dout     (tx_dout_s),
        .empty    (tx_empty_s),
        .full     (tx_full_s),
        .free_cnt (tx_free_s)
    );

    byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (rx_push_s),
        .pop      (rx_pop_s),
        .din      (rx_data),
        .dout     (rx_dout_s),
        .empty    (rx_empty_s),
        .full     (rx_full_s),
        .free_cnt (rx_free_s)
    );

    // ---------------- read source select ----------------
    logic [BYTE_W-1:0] io_rd_data_s;
    rd_sel_e           rd_sel_s;

    // IO read data and source for the registered read path
    always_comb begin
        io_rd_data_s = 8'h00;
        rd_sel_s     = SEL_NONE;
        if (io_s) begin
            rd_sel_s = SEL_IO;
            case (off_s)
                OFF_UART: io_rd_data_s = rx_empty_s ? 8'h00 : rx_dout_s;
                // Offset 4 returns the live counter; 5..7 the snapshot it takes
                OFF_CNT0: io_rd_data_s = cnt_r[7:0];
                OFF_CNT1: io_rd_data_s = byte_of(snap_r, 2'd1);
                OFF_CNT2: io_rd_data_s = byte_of(snap_r, 2'd2);
                OFF_CNT3: io_rd_data_s = byte_of(snap_r, 2'd3);
                default:  io_rd_data_s = 8'h00;
            endcase
        end else if (ram_hit_s) begin
            rd_sel_s = SEL_RAM;
        end else begin
            rd_sel_s = SEL_NONE;
        end
    end

    // RAM array: byte write and registered read; contents survive reset
    always_ff @(posedge clk_in) begin
        if (ram_we_s) ram_r[ram_idx_s] <= bus.mem_dout;
        if (cpu_rd_s) ram_q_r <= ram_r[ram_idx_s];
    end

    // Control/status registers, counter, snapshot and IO read register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            io_q_r         <= 8'h00;
            rd_sel_r       <= SEL_NONE;
            cnt_r          <= 32'd0;
            snap_r         <= 32'd0;
            program_done_r <= 1'b0;
            tx_overflow_r  <= 1'b0;
            io_full_r      <= 1'b0;
        end else begin
            if (bus.rdy_in) cnt_r <= cnt_r + 32'd1;
            if (cnt_rd_s)   snap_r <= cnt_r;
            if (cpu_rd_s) begin
                io_q_r   <= io_rd_data_s;
                rd_sel_r <= rd_sel_s;
            end
            if (stop_wr_s) program_done_r <= 1'b1;
            if (tx_push_req_s && tx_full_s && !tx_pop_s) tx_overflow_r <= 1'b1;
            io_full_r <= (tx_free_next_s <= (FIFO_AW+2)'(FULL_MARGIN));
        end
    end

    assign bus.mem_din        = (rd_sel_r == SEL_RAM) ? ram_q_r : io_q_r;
    assign bus.io_buffer_full = io_full_r;
    assign tx_data            = tx_dout_s;
    assign tx_valid           = !tx_empty_s;
    assign rx_ready           = !rx_full_s;
    assign program_done       = program_done_r;
    assign tx_overflow        = tx_overflow_r;

    assign unused_s = ^{bus.mem_a[ADDR_W-1:DEC_W], rx_free_s};

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       program_done;
    logic       tx_overflow;

    mem_io_responder_if bus();

    mem_io_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .program_done (program_done),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  q_tx[$];
    logic [31:0] m_cnt  = 32'd0;
    logic [31:0] m_snap = 32'd0;

    typedef struct {
        logic        rdy;
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;
    vec_t vt[15];

    // Negedge observer: records bytes leaving TX and models the cycle counter
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && tx_valid && tx_ready) q_tx.push_back(tx_data);
        if (rst_in !== 1'b1) begin
            m_cnt = 32'd0;
        end else if (bus.rdy_in === 1'b1) begin
            if (bus.mem_wr === 1'b0 && bus.mem_a == 32'h0003_0004) m_snap = m_cnt;
            m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic idle();
        bus.rdy_in   = 1'b1;
        bus.mem_wr   = 1'b0;
        bus.mem_a    = 32'h0002_0000;
        bus.mem_dout = 8'h00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.rdy_in = 1'b1; bus.mem_a = a; bus.mem_dout = d; bus.mem_wr = 1'b1;
        tick();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [7:0] d);
        bus.rdy_in = 1'b1; bus.mem_a = a; bus.mem_wr = 1'b0;
        tick();
        d = bus.mem_din;
        idle();
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        tx_ready = 1'b1;
        for (int k = 0; k < budget && tx_valid; k++) tick();
        chk("drain_done", {31'd0, tx_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] b0, b1, b2, b3, c0;
        vt[0]  = '{1'b1, 1'b1, 32'h0000_0010, 8'hA5, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vt[2]  = '{1'b1, 1'b0, 32'h0002_0000, 8'h00, 8'h00};
        vt[3]  = '{1'b1, 1'b1, 32'h0001_FFFF, 8'h5A, 8'h00};
        vt[4]  = '{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 8'h5A};
        vt[5]  = '{1'b1, 1'b1, 32'h0002_0005, 8'h77, 8'h5A};
        vt[6]  = '{1'b1, 1'b0, 32'h0002_0005, 8'h00, 8'h00};
        vt[7]  = '{1'b1, 1'b1, 32'h0000_0000, 8'hC3, 8'h00};
        vt[8]  = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 8'hC3};
        vt[10] = '{1'b0, 1'b0, 32'h0000_0010, 8'h00, 8'hC3};
        vt[11] = '{1'b0, 1'b1, 32'h0000_0010, 8'hFF, 8'hC3};
        vt[12] = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vt[13] = '{1'b1, 1'b0, 32'h0003_0001, 8'h00, 8'h00};
        vt[14] = '{1'b1, 1'b0, 32'h0003_0003, 8'h00, 8'h00};

        // ---- reset ----
        rst_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        idle();
        repeat (3) tick();
        chk("rst_mem_din",   {24'd0, bus.mem_din}, 32'd0);
        chk("rst_tx_valid",  {31'd0, tx_valid}, 32'd0);
        chk("rst_rx_ready",  {31'd0, rx_ready}, 32'd1);
        chk("rst_buf_full",  {31'd0, bus.io_buffer_full}, 32'd0);
        chk("rst_done",      {31'd0, program_done}, 32'd0);
        chk("rst_overflow",  {31'd0, tx_overflow}, 32'd0);
        rst_in = 1'b1;

        // ---- RAM / decode table ----
        for (int i = 0; i < 15; i++) begin
            bus.rdy_in = vt[i].rdy; bus.mem_wr = vt[i].wr;
            bus.mem_a  = vt[i].a;   bus.mem_dout = vt[i].d;
            tick();
            chk($sformatf("vec%0d_mem_din", i), {24'd0, bus.mem_din}, {24'd0, vt[i].exp});
        end
        idle();

        // ---- UART TX zero filter ----
        tx_ready = 1'b1;
        q_tx.delete();
        wr(32'h0003_0000, 8'h48);
        chk("tx_h_valid", {31'd0, tx_valid}, 32'd1);
        chk("tx_h_data",  {24'd0, tx_data}, 32'h48);
        wr(32'h0003_0000, 8'h00);
        repeat (5) tick();
        chk("tx_h_count", q_tx.size(), 32'd1);
        chk("tx_h_byte",  (q_tx.size() > 0) ? {24'd0, q_tx[0]} : 32'hDEAD, 32'h48);

        // ---- TX fill, near-full, overflow, full push+pop ----
        tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            wr(32'h0003_0000, 8'(i));
            if (i == 13) chk("buf_full_13", {31'd0, bus.io_buffer_full}, 32'd0);
            if (i == 14) chk("buf_full_14", {31'd0, bus.io_buffer_full}, 32'd1);
            if (i == 16) chk("ovf_16",      {31'd0, tx_overflow}, 32'd0);
            if (i == 17) chk("ovf_17",      {31'd0, tx_overflow}, 32'd1);
        end
        q_tx.delete();
        tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h12);
        drain(40);
        chk("tx_fill_count", q_tx.size(), 32'd17);
        for (int i = 0; i < 17; i++)
            chk($sformatf("tx_order%0d", i),
                (i < q_tx.size()) ? {24'd0, q_tx[i]} : 32'hDEAD,
                (i < 16) ? 32'(i + 1) : 32'h12);
        chk("buf_full_drained", {31'd0, bus.io_buffer_full}, 32'd0);

        // ---- counter snapshot and freeze ----
        repeat (100) tick();
        rd(32'h0003_0004, b0);
        rd(32'h0003_0005, b1);
        rd(32'h0003_0006, b2);
        rd(32'h0003_0007, b3);
        chk("cnt_word", {b3, b2, b1, b0}, m_snap);
        bus.rdy_in = 1'b0; bus.mem_a = 32'h0003_0004; bus.mem_wr = 1'b0;
        repeat (10) tick();
        chk("rdy_low_hold", {24'd0, bus.mem_din}, {24'd0, b3});
        rd(32'h0003_0004, c0);
        chk("cnt_frozen_b0", {24'd0, c0}, {24'd0, m_snap[7:0]});
        rd(32'h0003_0005, c0);
        chk("cnt_frozen_b1", {24'd0, c0}, {24'd0, m_snap[15:8]});

        // ---- UART RX ----
        rx_push(8'h31);
        rx_push(8'h32);
        rd(32'h0003_0000, c0); chk("rx_first",  {24'd0, c0}, 32'h31);
        rd(32'h0003_0000, c0); chk("rx_second", {24'd0, c0}, 32'h32);
        rd(32'h0003_0000, c0); chk("rx_empty",  {24'd0, c0}, 32'h00);
        rx_valid = 1'b1; rx_data = 8'h55;
        bus.mem_a = 32'h0003_0000; bus.mem_wr = 1'b0;
        tick();
        rx_valid = 1'b0;
        chk("rx_no_bypass", {24'd0, bus.mem_din}, 32'h00);
        idle();
        rd(32'h0003_0000, c0); chk("rx_after_bypass", {24'd0, c0}, 32'h55);
        for (int i = 0; i < 16; i++) rx_push(8'(8'h60 + i));
        chk("rx_ready_full", {31'd0, rx_ready}, 32'd0);
        rx_push(8'hEE);
        rd(32'h0003_0000, c0); chk("rx_full_head", {24'd0, c0}, 32'h60);
        chk("rx_ready_again", {31'd0, rx_ready}, 32'd1);

        // ---- stop register ----
        tx_ready = 1'b0;
        wr(32'h0003_0004, 8'h99);
        chk("stop_done",     {31'd0, program_done}, 32'd1);
        chk("stop_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("stop_tx_data",  {24'd0, tx_data}, 32'h00);
        wr(32'h0003_0000, 8'h41);
        q_tx.delete();
        drain(10);
        chk("stop_tx_count", q_tx.size(), 32'd1);
        chk("stop_tx_byte",  (q_tx.size() > 0) ? {24'd0, q_tx[0]} : 32'hDEAD, 32'h00);
        wr(32'h0000_0100, 8'h3C);
        rd(32'h0000_0100, c0); chk("ram_after_stop", {24'd0, c0}, 32'h3C);
        chk("done_sticky", {31'd0, program_done}, 32'd1);

        // ---- reset clears state, not RAM ----
        tx_ready = 1'b0;
        rst_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        chk("rst2_done",     {31'd0, program_done}, 32'd0);
        chk("rst2_overflow", {31'd0, tx_overflow}, 32'd0);
        chk("rst2_rx_ready", {31'd0, rx_ready}, 32'd1);
        rd(32'h0003_0000, c0); chk("rst2_rx_cleared", {24'd0, c0}, 32'h00);
        rd(32'h0003_0004, c0); chk("rst2_cnt", {24'd0, c0}, {24'd0, m_snap[7:0]});
        rd(32'h0000_0010, c0); chk("rst2_ram_kept", {24'd0, c0}, 32'hA5);
        wr(32'h0003_0000, 8'h41);
        chk("rst2_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("rst2_tx_data",  {24'd0, tx_data}, 32'h41);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
